// File: rtl/dig_ct_pkg.sv
// Shared definitions for the DigCt select-line code space and the dig_enc encoder.
// Code constants are also used by the DigCt loop-back bench.
package dig_ct_pkg;

    localparam logic [4:0] CODE_IDLE = 5'b00000;
    localparam logic [4:0] CODE_SEL1 = 5'b00100;
    localparam logic [4:0] CODE_SEL2 = 5'b00110;
    localparam logic [4:0] CODE_SEL3 = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_PRESENT      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } enc_state_t;

    // Pattern bit i is high when select line i+1 is pulled low; SEL3 wins over SEL2 over SEL1.
    function automatic logic [4:0] encode_pattern(input logic [2:0] pat);
        logic [4:0] code;
        if (pat[2])      code = CODE_SEL3;
        else if (pat[1]) code = CODE_SEL2;
        else if (pat[0]) code = CODE_SEL1;
        else             code = CODE_IDLE;
        return code;
    endfunction

    function automatic logic is_multi(input logic [2:0] pat);
        return (pat[0] & pat[1]) | (pat[0] & pat[2]) | (pat[1] & pat[2]);
    endfunction

endpackage

// File: rtl/dig_enc_sync.sv
// N-stage, W-bit synchroniser; resets to all-ones so idle (high) select lines look idle.
module dig_sync #(
    parameter int N = 2,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/dig_enc.sv
// Debounces the three active-low DigCt select lines and emits one 5-bit code per press
// through a valid/ready handshake.
module dig_enc
    import dig_ct_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SEL1_N,
    input  logic       SEL2_N,
    input  logic       SEL3_N,
    output logic [4:0] CODE,
    output logic       CODE_VALID,
    input  logic       CODE_READY,
    output logic       CODE_MULTI
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    logic [2:0] sel_sync;
    logic [2:0] pat_now;

    enc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       pat_q, pat_d;
    logic [4:0]       code_q, code_d;
    logic             multi_q, multi_d;

    dig_sync #(
        .N (SYNC_STAGES),
        .W (3)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   ({SEL3_N, SEL2_N, SEL1_N}),
        .q   (sel_sync)
    );

    assign pat_now = ~sel_sync;
    assign cnt_inc = cnt_q + CNT_ONE;

    // The code register only loads on entry to PRESENT, so CODE never glitches while valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        multi_d = multi_q;

        case (state_q)
            ST_IDLE: begin
                if (pat_now != 3'b000) begin
                    pat_d = pat_now;
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_PRESENT;
                        code_d  = encode_pattern(pat_now);
                        multi_d = is_multi(pat_now);
                    end else begin
                        state_d = ST_DEBOUNCE;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            ST_DEBOUNCE: begin
                if (pat_now == 3'b000) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (pat_now != pat_q) begin
                    pat_d = pat_now;
                    cnt_d = CNT_ONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESENT;
                    code_d  = encode_pattern(pat_q);
                    multi_d = is_multi(pat_q);
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_PRESENT: begin
                if (CODE_READY) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end

            ST_WAIT_RELEASE: begin
                // Any low sample restarts the release count, so a release bounce is absorbed.
                if (pat_now == 3'b000) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pat_q   <= 3'b000;
            code_q  <= CODE_IDLE;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            multi_q <= multi_d;
        end
    end

    assign CODE       = code_q;
    assign CODE_MULTI = multi_q;
    assign CODE_VALID = (state_q == ST_PRESENT);

endmodule

// File: tb/tb_dig_enc.sv
// Self-checking bench for dig_enc: directed press scenarios plus randomized line activity,
// compared every cycle against a sample-window reference model.
module tb_dig_enc;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel_n = 3'b111;
    logic       code_ready = 1'b0;
    logic [4:0] code;
    logic       code_valid;
    logic       code_multi;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw line history, window of synchronised patterns, expected outputs.
    typedef enum {M_ARMED, M_SHOWING, M_RELEASING} model_mode_t;
    model_mode_t mode = M_ARMED;
    logic [2:0]  raw_hist [SYNC_STAGES];
    logic [2:0]  win [STABLE_CYCLES];
    int          rel_seen = 0;
    logic [4:0]  exp_code = 5'b00000;
    logic        exp_valid = 1'b0;
    logic        exp_multi = 1'b0;

    dig_enc #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .SEL1_N     (sel_n[0]),
        .SEL2_N     (sel_n[1]),
        .SEL3_N     (sel_n[2]),
        .CODE       (code),
        .CODE_VALID (code_valid),
        .CODE_READY (code_ready),
        .CODE_MULTI (code_multi)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [4:0] refCode(input logic [2:0] p);
        if (p[2]) return 5'b01000;
        if (p[1]) return 5'b00110;
        if (p[0]) return 5'b00100;
        return 5'b00000;
    endfunction

    function automatic bit windowSameNonZero();
        for (int i = 1; i < STABLE_CYCLES; i++) begin
            if (win[i] != win[0]) return 1'b0;
        end
        return win[0] != 3'b000;
    endfunction

    function automatic bit windowAllZero();
        for (int i = 0; i < STABLE_CYCLES; i++) begin
            if (win[i] != 3'b000) return 1'b0;
        end
        return 1'b1;
    endfunction

    // A press is accepted once the last STABLE_CYCLES synchronised samples agree and are non-idle;
    // after a transfer, STABLE_CYCLES idle samples taken since the transfer re-arm the encoder.
    task automatic modelEdge();
        logic [2:0] p;
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) raw_hist[i] = 3'b000;
            for (int i = 0; i < STABLE_CYCLES; i++) win[i] = 3'b000;
            mode = M_ARMED;
            exp_code = 5'b00000;
            exp_valid = 1'b0;
            exp_multi = 1'b0;
            return;
        end
        p = raw_hist[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) raw_hist[i] = raw_hist[i-1];
        raw_hist[0] = ~sel_n;
        for (int i = STABLE_CYCLES - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = p;
        case (mode)
            M_ARMED: begin
                if (windowSameNonZero()) begin
                    mode = M_SHOWING;
                    exp_valid = 1'b1;
                    exp_code = refCode(p);
                    exp_multi = ($countones(p) >= 2);
                end
            end
            M_SHOWING: begin
                if (code_ready) begin
                    mode = M_RELEASING;
                    exp_valid = 1'b0;
                    rel_seen = 0;
                end
            end
            default: begin
                rel_seen++;
                if (rel_seen >= STABLE_CYCLES && windowAllZero()) mode = M_ARMED;
            end
        endcase
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("valid", {7'b0, code_valid}, {7'b0, exp_valid});
        checkOutput("code", {3'b0, code}, {3'b0, exp_code});
        checkOutput("multi", {7'b0, code_multi}, {7'b0, exp_multi});
    endtask

    task automatic applyStimulus(input logic [2:0] lines, input logic ready, input int cycles);
        sel_n = lines;
        code_ready = ready;
        for (int i = 0; i < cycles; i++) stepCycle();
    endtask

    // Steps until CODE_VALID rises; returns the number of edges taken, or 0 if the budget expires.
    task automatic waitValid(output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            stepCycle();
            if (code_valid) begin
                edges = i;
                return;
            end
        end
    endtask

    initial begin
        int n;
        int len;
        int sum_valid;
        logic [2:0] lines;

        $display("[TB] starting dig_enc bench");
        rst = 1'b1;
        applyStimulus(3'b111, 1'b1, 3);
        rst = 1'b0;
        applyStimulus(3'b111, 1'b1, 6);

        // SEL1 press with READY high: fixed latency, then a long hold yields exactly one code.
        sel_n = 3'b110;
        waitValid(n);
        checkOutput("sel1_latency", 8'(n), 8'(SYNC_STAGES + STABLE_CYCLES));
        checkOutput("sel1_code", {3'b0, code}, 8'h04);
        sum_valid = 0;
        for (int i = 0; i < 50; i++) begin
            stepCycle();
            if (code_valid) sum_valid++;
        end
        checkOutput("sel1_single", 8'(sum_valid), 8'd0);

        // Release bounce, then SEL2 held while READY is low and the lines wander.
        applyStimulus(3'b111, 1'b1, 3);
        applyStimulus(3'b110, 1'b1, 1);
        applyStimulus(3'b111, 1'b1, 10);
        applyStimulus(3'b101, 1'b0, 10);
        applyStimulus(3'b010, 1'b0, 5);
        applyStimulus(3'b111, 1'b0, 5);
        checkOutput("sel2_held", {3'b0, code}, 8'h06);
        applyStimulus(3'b111, 1'b1, 10);

        // Two lines together, then SEL1 alone.
        applyStimulus(3'b010, 1'b1, 12);
        applyStimulus(3'b111, 1'b1, 10);
        applyStimulus(3'b110, 1'b1, 12);
        applyStimulus(3'b111, 1'b1, 10);

        // Short bounce is ignored; a bounce that becomes SEL2 restarts the debounce.
        applyStimulus(3'b110, 1'b1, 3);
        applyStimulus(3'b111, 1'b1, 10);
        applyStimulus(3'b110, 1'b1, 3);
        applyStimulus(3'b101, 1'b1, 10);
        applyStimulus(3'b111, 1'b1, 10);

        // Reset while a code waits: it drops and is re-emitted after a full debounce.
        sel_n = 3'b101;
        code_ready = 1'b0;
        waitValid(n);
        checkOutput("pre_rst_valid", {7'b0, code_valid}, 8'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        waitValid(n);
        checkOutput("rst_relatency", 8'(n), 8'(SYNC_STAGES + STABLE_CYCLES));
        applyStimulus(3'b111, 1'b1, 10);

        // Randomized line activity, READY pattern and occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 9) < 4) lines = 3'b111;
            else lines = 3'($urandom_range(0, 6));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 20)) : int'($urandom_range(1, 6));
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < len; c++) begin
                sel_n = lines;
                code_ready = ($urandom_range(0, 3) != 0);
                stepCycle();
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dig_enc.md
Name: dig_enc

Overview:
- Reverse direction of the DigCt decoder, which maps a 5-bit input code onto three active-low select lines. dig_enc watches the three active-low lines, debounces them and emits the matching 5-bit code through a valid/ready handshake.
- Used for loop-back checking of DigCt and for front-panel/strap encoding into the same 5-bit code space.
- One emitted code per press. A new code is emitted only after the lines have returned to idle (all high).

Parameters:
- SYNC_STAGES, 2, synchroniser depth on the select lines; must be at least 1.
- STABLE_CYCLES, 4, number of consecutive identical synchronised samples needed to accept a pattern or a release; must be at least 1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- SEL1_N  input  1  active-low select line 1 (the line DigCt drives as OUT1).
- SEL2_N  input  1  active-low select line 2 (the line DigCt drives as OUT2).
- SEL3_N  input  1  active-low select line 3 (the line DigCt drives as OUT3).
- CODE  output  5  encoded value; bit0 corresponds to DigCt IN1 and bit4 to DigCt IN5.
- CODE_VALID  output  1  CODE is valid.
- CODE_READY  input  1  consumer accepts CODE.
- CODE_MULTI  output  1  more than one line was low in the accepted pattern; qualified by CODE_VALID.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: CODE=5'b00000, CODE_VALID=0, CODE_MULTI=0, FSM in IDLE, debounce count 0, all synchroniser flops 1 (idle level).
- Synchroniser: s = {SEL3_N, SEL2_N, SEL1_N} delayed by SYNC_STAGES flops. Pattern p = ~s.
- Encoding, with priority SEL3 > SEL2 > SEL1:
  - SEL3 low → 5'b01000.
  - else SEL2 low → 5'b00110.
  - else SEL1 low → 5'b00100.
  - CODE_MULTI = 1 when popcount(p) ≥ 2.
- FSM states: IDLE, DEBOUNCE, PRESENT, WAIT_RELEASE.
- IDLE:
  - p == 0 → stay.
  - p != 0 → latch pat=p.
    - If STABLE_CYCLES == 1, go to PRESENT.
    - Otherwise go to DEBOUNCE with cnt=1.
- DEBOUNCE:
  - p == 0 → IDLE.
  - p != pat → pat=p, cnt=1.
  - p == pat and cnt == STABLE_CYCLES-1 → PRESENT.
  - Otherwise cnt++.
- Entering PRESENT: CODE and CODE_MULTI are loaded from pat, and CODE_VALID=1 from the same edge.
- Latency: lines change and then hold from the first sampling edge k. CODE_VALID rises after edge k+SYNC_STAGES+STABLE_CYCLES-1; with the defaults this is k+5.
- PRESENT:
  - CODE and CODE_MULTI are held constant while CODE_VALID=1, whatever the lines do (no glitching, no re-encode).
  - A transfer happens on any edge with CODE_VALID && CODE_READY. On that edge: CODE_VALID=0, CODE and CODE_MULTI keep their values, cnt=0, go to WAIT_RELEASE.
  - CODE_READY is ignored while CODE_VALID=0.
- WAIT_RELEASE:
  - p == 0 → cnt++; when cnt reaches STABLE_CYCLES, go to IDLE.
  - p != 0 → cnt=0.
  - No new code is produced until the release is accepted, so a held line yields exactly one code.
- Bounce shorter than STABLE_CYCLES samples is never emitted.
- Counter width is $clog2(STABLE_CYCLES+1). It never wraps because it saturates at the threshold.
- RST mid-operation: asserting RST in any state returns to the reset values on the next edge, including dropping CODE_VALID with no transfer. The synchroniser reloads to 1, so lines already held low must pass the full debounce again after RST drops.
- Simultaneous events: a transfer edge takes precedence over any line change on the same edge. The line change is evaluated from WAIT_RELEASE onward.

Decomposition:
- Shared package dig_ct_pkg:
  - Code constants CODE_IDLE=5'b00000, CODE_SEL1=5'b00100, CODE_SEL2=5'b00110, CODE_SEL3=5'b01000, also used by the DigCt bench for loop-back.
  - FSM state encoding for dig_enc.
- One sub-module, dig_sync: parameterised N-stage, W-bit synchroniser with synchronous active-high reset to all-ones.
- Debounce counter, FSM and encoder stay in dig_enc.

Test Plan:
- Defaults, CODE_READY=1. SEL1_N low from edge 10 → CODE_VALID high after edge 15, CODE=5'b00100, CODE_MULTI=0, one-cycle valid. Hold low 50 cycles → no second code.
- SEL2_N low with CODE_READY=0 for 20 cycles, lines toggled during wait → CODE stays 5'b00110 with CODE_VALID=1 throughout. READY=1 → transfer on the next edge, then CODE_VALID=0.
- SEL3_N and SEL1_N low together → CODE=5'b01000, CODE_MULTI=1. Release then SEL1_N alone → CODE=5'b00100, CODE_MULTI=0.
- SEL1_N low for 3 cycles then high (bounce) → CODE_VALID never asserts. SEL1_N low 3 cycles then SEL2_N low → debounce restarts, CODE=5'b00110 emitted.
- Release bounce: after a transfer, lines high 3 cycles, low 1, then high → IDLE reached only after 4 consecutive high samples. The next press is emitted exactly once.
- RST asserted for 1 cycle while CODE_VALID=1 and READY=0 → next edge CODE_VALID=0, CODE=0. Line still low → code re-emitted 6 edges after RST deasserts.
